pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_if.sv | 43 ++++
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the hazard controller and the pipeline datapath:
// hazard/sequencing inputs from ID/EX plus the enable/flush pins it drives.
interface pipeline_ctrl_if #(
    parameter int unsigned ADR_W = 3
);
    logic [ADR_W-1:0] rs_adr_id;
    logic [ADR_W-1:0] rt_adr_id;
    logic             rs_used_id;
    logic             rt_used_id;
    logic             regwrite_ex;
    logic [ADR_W-1:0] regwrite_adr_ex;
    logic             mem_read_ex;
    logic             branch_taken_ex;
    logic             is_halt_ex;
    logic             restart;
    logic             mem_busy;

    logic             en_pc;
    logic             en_ifid;
    logic             flush_ifid;
    logic             en_idex;
    logic             flush_idex;
    logic             en_exmem;
    logic             halted;
    logic [15:0]      stall_count;

    // Datapath side: presents stage status, consumes enables and flushes.
    modport master (
        output rs_adr_id, rt_adr_id, rs_used_id, rt_used_id, regwrite_ex,
               regwrite_adr_ex, mem_read_ex, branch_taken_ex, is_halt_ex,
               restart, mem_busy,
        input  en_pc, en_ifid, flush_ifid, en_idex, flush_idex, en_exmem,
               halted, stall_count
    );

    modport slave (
        input  rs_adr_id, rt_adr_id, rs_used_id, rt_used_id, regwrite_ex,
               regwrite_adr_ex, mem_read_ex, branch_taken_ex, is_halt_ex,
               restart, mem_busy,
        output en_pc, en_ifid, flush_ifid, en_idex, flush_idex, en_exmem,
               halted, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: memory wait, halt,
// taken branch and load-use bubbles, plus a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int unsigned LU_STALL = 1,
    parameter int unsigned ADR_W    = 3
) (
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LU_WAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    localparam logic [2:0] LU_EXTRA = 3'(LU_STALL - 1);

    state_t      state_q, state_nxt;
    logic [2:0]  cnt_q, cnt_nxt;
    logic [15:0] stall_q;
    logic        stall_inc;

    logic [ADR_W-1:0] wr_adr;
    logic             rs_match;
    logic             rt_match;
    logic             hazard;

    assign wr_adr   = bus.regwrite_adr_ex;
    assign rs_match = bus.rs_used_id && (bus.rs_adr_id == wr_adr);
    assign rt_match = bus.rt_used_id && (bus.rt_adr_id == wr_adr);
    assign hazard   = bus.mem_read_ex && bus.regwrite_ex && (rs_match || rt_match);

    always_comb begin
        // NOTE: every output and next-state term gets a default first, so no path infers a latch.
        bus.en_pc      = 1'b1;
        bus.en_ifid    = 1'b1;
        bus.flush_ifid = 1'b0;
        bus.en_idex    = 1'b1;
        bus.flush_idex = 1'b0;
        bus.en_exmem   = 1'b1;
        bus.halted     = 1'b0;
        state_nxt      = state_q;
        cnt_nxt        = cnt_q;

        if (reset) begin
            bus.en_pc      = 1'b0;
            bus.en_ifid    = 1'b0;
            bus.en_idex    = 1'b0;
            bus.en_exmem   = 1'b0;
            bus.flush_ifid = 1'b1;
            bus.flush_idex = 1'b1;
        end else if (bus.mem_busy) begin
            // Whole pipe freezes; FSM and bubble counter hold their values.
            bus.en_pc    = 1'b0;
            bus.en_ifid  = 1'b0;
            bus.en_idex  = 1'b0;
            bus.en_exmem = 1'b0;
            bus.halted   = (state_q == HALTED);
        end else begin
            case (state_q)
                RUN, LU_WAIT: begin
                    if (bus.is_halt_ex) begin
                        bus.en_pc      = 1'b0;
                        bus.flush_ifid = 1'b1;
                        bus.flush_idex = 1'b1;
                        state_nxt      = HALTED;
                        cnt_nxt        = 3'd0;
                    end else if (bus.branch_taken_ex) begin
                        bus.flush_ifid = 1'b1;
                        bus.flush_idex = 1'b1;
                        state_nxt      = RUN;
                        cnt_nxt        = 3'd0;
                    end else if (state_q == LU_WAIT || hazard) begin
                        // Hold PC and IF/ID, push a bubble into ID/EX.
                        bus.en_pc      = 1'b0;
                        bus.en_ifid    = 1'b0;
                        bus.flush_idex = 1'b1;
                        if (state_q == LU_WAIT) begin
                            cnt_nxt = cnt_q - 3'd1;
                            if (cnt_q == 3'd1) begin
                                state_nxt = RUN;
                            end
                        end else if (LU_STALL > 1) begin
                            state_nxt = LU_WAIT;
                            cnt_nxt   = LU_EXTRA;
                        end
                    end
                end
                HALTED: begin
                    bus.en_pc   = 1'b0;
                    bus.en_ifid = 1'b0;
                    bus.en_idex = 1'b0;
                    bus.halted  = 1'b1;
                    if (bus.restart) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end

        stall_inc = !reset && !bus.en_pc && (state_q != HALTED);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            if (stall_inc && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: two controllers (LU_STALL = 1 and 3) share stimulus and are
// compared to a bubble-budget reference model, a vector table and corner sequences.
module tb_pipeline_ctrl;

    typedef struct packed {
        bit       rst;
        bit       busy;
        bit       hlt;
        bit       br;
        bit       rp;
        bit       mr;
        bit       rw;
        bit [2:0] wadr;
        bit       rs_u;
        bit [2:0] rs;
        bit       rt_u;
        bit [2:0] rt;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [6:0]  outs;
        bit          chk_cnt;
        logic [15:0] cnt;
    } vec_t;

    localparam bit O = 1'b0;
    localparam bit I = 1'b1;
    // Output vector order: {en_pc, en_ifid, flush_ifid, en_idex, flush_idex, en_exmem, halted}
    localparam logic [6:0] P_RESET  = 7'b0010100;
    localparam logic [6:0] P_RUN    = 7'b1101010;
    localparam logic [6:0] P_BUBBLE = 7'b0001110;
    localparam logic [6:0] P_BRANCH = 7'b1111110;
    localparam logic [6:0] P_HALTC  = 7'b0111110;
    localparam logic [6:0] P_HALTED = 7'b0000011;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    pipeline_ctrl_if #(.ADR_W(3)) if1 ();
    pipeline_ctrl_if #(.ADR_W(3)) if3 ();

    pipeline_ctrl #(.LU_STALL(1), .ADR_W(3)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    pipeline_ctrl #(.LU_STALL(3), .ADR_W(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending-bubble budget, halted flag and stall tally per controller.
    int         ls[2] = '{1, 3};
    int         m_left[2];
    bit         m_halted[2];
    int         m_cnt[2];
    bit         cnt_known;
    logic [6:0] last_o[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(bit rst, bit busy, bit hlt, bit br, bit rp, bit mr, bit rw,
                                 int wadr, bit rsu, int rs, bit rtu, int rt);
        stim_t s;
        s.rst  = rst;   s.busy = busy; s.hlt = hlt; s.br = br; s.rp = rp;
        s.mr   = mr;    s.rw   = rw;   s.wadr = 3'(wadr);
        s.rs_u = rsu;   s.rs   = 3'(rs);
        s.rt_u = rtu;   s.rt   = 3'(rt);
        return s;
    endfunction

    function automatic bit reads_loaded_reg(stim_t s);
        bit [2:0] srcs[$];
        if (!(s.mr && s.rw)) return 1'b0;
        if (s.rs_u) srcs.push_back(s.rs);
        if (s.rt_u) srcs.push_back(s.rt);
        foreach (srcs[i]) if (srcs[i] == s.wadr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] model_outs(int k, stim_t s);
        if (s.rst)                                     return P_RESET;
        if (s.busy)                                    return {6'b0, m_halted[k]};
        if (m_halted[k])                               return P_HALTED;
        if (s.hlt)                                     return P_HALTC;
        if (s.br)                                      return P_BRANCH;
        if (m_left[k] > 0 || reads_loaded_reg(s))      return P_BUBBLE;
        return P_RUN;
    endfunction

    task automatic model_step(int k, stim_t s);
        logic [6:0] o;
        o = model_outs(k, s);
        if (s.rst) begin
            m_halted[k] = 1'b0;
            m_left[k]   = 0;
            m_cnt[k]    = 0;
            return;
        end
        if (!o[6] && !m_halted[k] && m_cnt[k] < 65535) m_cnt[k]++;
        if (s.busy) return;
        if (m_halted[k]) begin
            if (s.rp) m_halted[k] = 1'b0;
        end else if (s.hlt) begin
            m_halted[k] = 1'b1;
            m_left[k]   = 0;
        end else if (s.br) begin
            m_left[k] = 0;
        end else if (m_left[k] > 0) begin
            m_left[k]--;
        end else if (reads_loaded_reg(s)) begin
            m_left[k] = ls[k] - 1;
        end
    endtask

    function automatic logic [6:0] dut_outs(int k);
        if (k == 0)
            return {if1.en_pc, if1.en_ifid, if1.flush_ifid, if1.en_idex, if1.flush_idex,
                    if1.en_exmem, if1.halted};
        return {if3.en_pc, if3.en_ifid, if3.flush_ifid, if3.en_idex, if3.flush_idex,
                if3.en_exmem, if3.halted};
    endfunction

    function automatic logic [15:0] dut_cnt(int k);
        return (k == 0) ? if1.stall_count : if3.stall_count;
    endfunction

    task automatic drive(stim_t s);
        reset = s.rst;
        if1.mem_busy = s.busy;        if3.mem_busy = s.busy;
        if1.is_halt_ex = s.hlt;       if3.is_halt_ex = s.hlt;
        if1.branch_taken_ex = s.br;   if3.branch_taken_ex = s.br;
        if1.restart = s.rp;           if3.restart = s.rp;
        if1.mem_read_ex = s.mr;       if3.mem_read_ex = s.mr;
        if1.regwrite_ex = s.rw;       if3.regwrite_ex = s.rw;
        if1.regwrite_adr_ex = s.wadr; if3.regwrite_adr_ex = s.wadr;
        if1.rs_used_id = s.rs_u;      if3.rs_used_id = s.rs_u;
        if1.rs_adr_id = s.rs;         if3.rs_adr_id = s.rs;
        if1.rt_used_id = s.rt_u;      if3.rt_used_id = s.rt_u;
        if1.rt_adr_id = s.rt;         if3.rt_adr_id = s.rt;
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic settle(stim_t s);
        drive(s);
        @(negedge clk);
        for (int k = 0; k < 2; k++) last_o[k] = dut_outs(k);
    endtask

    task automatic model_check(stim_t s);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("model_outs[L%0d]", ls[k]), 32'(last_o[k]), 32'(model_outs(k, s)));
            if (cnt_known)
                check($sformatf("model_stall[L%0d]", ls[k]), 32'(dut_cnt(k)), 32'(m_cnt[k]));
        end
    endtask

    task automatic advance(stim_t s);
        for (int k = 0; k < 2; k++) model_step(k, s);
        if (s.rst) cnt_known = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step(stim_t s, bit chk);
        settle(s);
        if (chk) model_check(s);
        advance(s);
    endtask

    vec_t  tbl[18];
    stim_t idle_s, rst_s, busy_s, halt_s, rp_s, lu_rt3;
    int    lows1, lows3;

    initial begin
        total = 0;
        bad   = 0;
        cnt_known = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_halted[k] = 1'b0; m_cnt[k] = 0;
        end

        idle_s = mk(O,O,O,O,O, O,O,0, O,0, O,0);
        rst_s  = mk(I,O,O,O,O, O,O,0, O,0, O,0);
        busy_s = mk(O,I,O,O,O, O,O,0, O,0, O,0);
        halt_s = mk(O,O,I,O,O, O,O,0, O,0, O,0);
        rp_s   = mk(O,O,O,O,I, O,O,0, O,0, O,0);
        lu_rt3 = mk(O,O,O,O,O, I,I,3, O,0, I,3);

        tbl[0]  = '{rst_s,                                 P_RESET,  O, 16'd0};
        tbl[1]  = '{rst_s,                                 P_RESET,  I, 16'd0};
        tbl[2]  = '{idle_s,                                P_RUN,    I, 16'd0};
        tbl[3]  = '{lu_rt3,                                P_BUBBLE, I, 16'd0};
        tbl[4]  = '{idle_s,                                P_RUN,    I, 16'd1};
        tbl[5]  = '{mk(O,O,O,I,O, I,I,3, O,0, I,3),        P_BRANCH, I, 16'd1};
        tbl[6]  = '{idle_s,                                P_RUN,    I, 16'd1};
        tbl[7]  = '{mk(O,O,O,O,O, I,I,0, I,0, O,0),        P_BUBBLE, I, 16'd1};
        tbl[8]  = '{mk(O,O,O,O,O, I,I,5, O,5, O,0),        P_RUN,    I, 16'd2};
        tbl[9]  = '{mk(O,O,O,O,O, I,O,2, I,2, I,2),        P_RUN,    I, 16'd2};
        tbl[10] = '{halt_s,                                P_HALTC,  I, 16'd2};
        tbl[11] = '{idle_s,                                P_HALTED, I, 16'd3};
        tbl[12] = '{mk(O,O,O,I,O, I,I,3, O,0, I,3),        P_HALTED, I, 16'd3};
        tbl[13] = '{rp_s,                                  P_HALTED, I, 16'd3};
        tbl[14] = '{idle_s,                                P_RUN,    I, 16'd3};
        tbl[15] = '{rp_s,                                  P_RUN,    I, 16'd3};
        tbl[16] = '{busy_s,                                7'b0,     I, 16'd3};
        tbl[17] = '{idle_s,                                P_RUN,    I, 16'd4};

        #1;
        for (int i = 0; i < 18; i++) begin
            settle(tbl[i].s);
            check($sformatf("tbl%0d_outs", i), 32'(last_o[0]), 32'(tbl[i].outs));
            if (tbl[i].chk_cnt)
                check($sformatf("tbl%0d_stall", i), 32'(dut_cnt(0)), 32'(tbl[i].cnt));
            model_check(tbl[i].s);
            advance(tbl[i].s);
        end

        // Load-use bubble length for LU_STALL = 1 and 3.
        step(rst_s, 1'b1);
        lows1 = 0; lows3 = 0;
        for (int i = 0; i < 5; i++) begin
            step((i == 0) ? lu_rt3 : idle_s, 1'b1);
            if (!last_o[0][6]) lows1++;
            if (!last_o[1][6]) lows3++;
        end
        check("lu1_bubbles", 32'(lows1), 32'd1);
        check("lu3_bubbles", 32'(lows3), 32'd3);
        settle(idle_s);
        check("lu1_stall", 32'(dut_cnt(0)), 32'd1);
        check("lu3_stall", 32'(dut_cnt(1)), 32'd3);
        advance(idle_s);

        // Halt: one flush cycle, ten halted cycles draining EX/MEM, then restart.
        step(rst_s, 1'b1);
        step(halt_s, 1'b1);
        check("halt_flush", 32'(last_o[0]), 32'(P_HALTC));
        for (int i = 0; i < 10; i++) begin
            settle(idle_s);
            check("halted_hold", 32'({last_o[0][6], last_o[0][1], last_o[0][0]}), 32'b011);
            check("halted_stall", 32'(dut_cnt(0)), 32'd1);
            model_check(idle_s);
            advance(idle_s);
        end
        step(rp_s, 1'b1);
        check("restart_cycle_halted", 32'(last_o[0][0]), 32'd1);
        step(idle_s, 1'b1);
        check("after_restart", 32'(last_o[0]), 32'(P_RUN));

        // mem_busy for four cycles inside LU_WAIT freezes the bubble count.
        step(rst_s, 1'b1);
        step(lu_rt3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(busy_s, 1'b1);
            check("busy_in_luwait", 32'(last_o[1]), 32'd0);
        end
        lows3 = 0;
        for (int i = 0; i < 3; i++) begin
            step(idle_s, 1'b1);
            if (!last_o[1][6]) lows3++;
        end
        check("luwait_resume_bubbles", 32'(lows3), 32'd2);
        settle(idle_s);
        check("luwait_busy_stall", 32'(dut_cnt(1)), 32'd7);
        advance(idle_s);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            stim_t s;
            s = mk(($urandom_range(39) == 0), ($urandom_range(5) == 0),
                   ($urandom_range(19) == 0), ($urandom_range(5) == 0),
                   ($urandom_range(7) == 0), 1'($urandom), 1'($urandom),
                   int'($urandom_range(3)), 1'($urandom), int'($urandom_range(3)),
                   1'($urandom), int'($urandom_range(3)));
            step(s, 1'b1);
        end

        // Saturation: run the counter up to 0xFFFE, stall three more cycles.
        step(rst_s, 1'b1);
        for (int i = 0; i < 65534; i++) step(busy_s, 1'b0);
        settle(busy_s);
        check("sat_pre", 32'(dut_cnt(0)), 32'hFFFE);
        model_check(busy_s);
        advance(busy_s);
        step(busy_s, 1'b1);
        step(busy_s, 1'b1);
        settle(idle_s);
        check("sat_hold", 32'(dut_cnt(0)), 32'hFFFF);
        check("sat_hold3", 32'(dut_cnt(1)), 32'hFFFF);
        model_check(idle_s);
        advance(idle_s);

        // Reset while HALTED returns straight to RUN with a cleared counter.
        step(halt_s, 1'b1);
        step(idle_s, 1'b1);
        step(rst_s, 1'b1);
        settle(idle_s);
        check("rst_halted_outs", 32'(last_o[0]), 32'(P_RUN));
        check("rst_halted_stall", 32'(dut_cnt(0)), 32'd0);
        model_check(idle_s);
        advance(idle_s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
